iccm_uart_loader: RTL and testbench
===================================

ICCM_UART_LOADER -- requirements
Module: iccm_uart_loader

Interface
REQ-001 clk_i  input  1  system clock; all state on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-high reset.
REQ-003 prog_i  input  1  programming-button level from pad; asynchronous, 2-flop synchronised internally.
REQ-004 uart_rx_i  input  1  serial 8N1 line, idle high; asynchronous, 2-flop synchronised internally.
REQ-005 clks_per_bit_i  input  16  clock cycles per UART bit, driven from the logic analyser; quasi-static.
REQ-006 mem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-007 mem_addr_o  output  12  word address of the write.
REQ-008 mem_wdata_o  output  32  write data.
REQ-009 core_rst_o  output  1  holds the SoC core in reset while loading.
REQ-010 busy_o  output  1  high in LOAD.
REQ-011 done_o  output  1  high in DONE.
REQ-012 err_o  output  1  sticky frame-error flag (see Configuration).

Function
REQ-013 The receiver SHALL run states RX_IDLE, RX_START, RX_DATA and RX_STOP, clocked by one 16-bit bit-timer.
- RX_IDLE -> RX_START on a synchronised falling edge.
- RX_START: wait clks_per_bit_i/2 (integer floor) cycles, then resample. Low -> RX_DATA. High -> RX_IDLE (glitch).
- RX_DATA: sample 8 bits, LSB first, one every clks_per_bit_i cycles.
- RX_STOP: wait clks_per_bit_i cycles, sample the stop bit, emit a one-cycle rx_valid with the byte, return to RX_IDLE.
REQ-014 If clks_per_bit_i < 4, the receiver SHALL stay in RX_IDLE and emit no bytes.
REQ-015 The loader SHALL run states IDLE, LOAD and DONE.
- IDLE/DONE -> LOAD on a synchronised prog rising edge: addr=0, byte_cnt=0, word=0.
REQ-016 In LOAD, each rx_valid byte SHALL be placed in word[8*byte_cnt+7 : 8*byte_cnt] (little-endian), and byte_cnt SHALL increment modulo 4.
REQ-017 On the 4th byte, if the assembled word equals END_WORD (32'h0000_0FFF), the loader SHALL enter DONE without writing.
REQ-018 Otherwise the loader SHALL assert mem_we_o for exactly one cycle, on the cycle after the 4th-byte rx_valid, with mem_addr_o=addr and mem_wdata_o=word, then increment addr.
REQ-019 addr SHALL wrap from 4095 to 0 without a flag.
REQ-020 A synchronised prog falling edge in LOAD SHALL abort to IDLE; a partial word is discarded, no write occurs, and done_o stays 0.
REQ-021 A prog rising edge while in LOAD SHALL be impossible by construction (prog is already high) and needs no handling.
REQ-022 core_rst_o SHALL equal busy_o; in IDLE and DONE, core_rst_o=0.
REQ-023 mem_addr_o and mem_wdata_o SHALL hold their last values when mem_we_o=0.

Reset
REQ-024 On rst_i, asynchronously, all outputs SHALL go to 0.
- Loader in IDLE, receiver in RX_IDLE.
- Counters and word cleared; synchronisers set to 1 (uart) and 0 (prog).
REQ-025 Reset mid-byte or mid-word SHALL discard all partial data, with no write on release.

Configuration
REQ-026 With LOADER_FRAME_CHECK_EN defined, a low stop-bit sample SHALL suppress rx_valid for that byte and set err_o.
- err_o stays set until reset or the next LOAD entry.
REQ-027 Without LOADER_FRAME_CHECK_EN, the stop bit SHALL be ignored (byte always delivered) and err_o SHALL be tied 0.

Structure
REQ-028 Package loader_pkg SHALL hold END_WORD, the loader and receiver state enums, and MIN_CLKS_PER_BIT=4.
REQ-029 The receiver SHALL be a separate sub-module, uart_rx_core (ports: clk_i, rst_i, rx_i, clks_per_bit_i, valid_o, data_o[7:0], frame_err_o).

Verification
REQ-030 clks_per_bit=16; prog rises; bytes 78 56 34 12 are sent -> one mem_we_o pulse with addr 0 and data 32'h12345678; busy_o=1; core_rst_o=1.
REQ-031 Two words are sent, then FF 0F 00 00 -> writes at addr 0 and 1 only; then done_o=1, busy_o=0, core_rst_o=0.
REQ-032 prog falls after 2 bytes of a word -> IDLE, no write; on the next prog rise, the first word is written at addr 0.
REQ-033 A 1/4-bit low glitch on rx in LOAD -> no byte received, no write.
REQ-034 With LOADER_FRAME_CHECK_EN, a byte with stop bit 0 -> err_o=1 and byte_cnt unchanged; without the macro -> byte accepted and err_o=0.
REQ-035 4097 words are sent -> the 4097th write goes to addr 0; rst_i pulsed mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and state types for the ICCM UART loader.
package loader_pkg;
  localparam logic [31:0] END_WORD = 32'h0000_0FFF;
  localparam logic [15:0] MIN_CLKS_PER_BIT = 16'd4;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with a 2-flop input synchroniser and one shared bit timer.
module uart_rx_core import loader_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [15:0] clks_per_bit_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        frame_err_o
);
  rx_state_e   state_q, state_d;
  logic        rx1_q, rx2_q, rxp_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d;
  logic        bit_end;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    bit_end = cnt_q == clks_per_bit_i - 16'd1;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rxp_q && !rx2_q && clks_per_bit_i >= MIN_CLKS_PER_BIT) state_d = RX_START;
      end
      RX_START:
        if (cnt_q == (clks_per_bit_i >> 1) - 16'd1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx2_q ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (bit_end) begin
          cnt_d   = '0;
          data_d  = {rx2_q, data_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (bit_end) begin
          state_d = RX_IDLE;
          valid_d = 1'b1;
          ferr_d  = !rx2_q;
        end
      default: state_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= RX_IDLE;
      rx1_q   <= 1'b1;
      rx2_q   <= 1'b1;
      rxp_q   <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx1_q   <= rx_i;
      rx2_q   <= rx1_q;
      rxp_q   <= rx2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = ferr_q;
endmodule

// File: rtl/iccm_uart_loader.sv
// iccm_uart_loader: streams little-endian words from a UART into instruction memory.
// Define LOADER_FRAME_CHECK_EN to drop bytes with a bad stop bit and raise a sticky err_o.
module iccm_uart_loader import loader_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        prog_i,
  input  logic        uart_rx_i,
  input  logic [15:0] clks_per_bit_i,
  output logic        mem_we_o,
  output logic [11:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
`ifdef LOADER_FRAME_CHECK_EN
  localparam logic FRAME_CHECK = 1'b1;
`else
  localparam logic FRAME_CHECK = 1'b0;
`endif
  ld_state_e   state_q, state_d;
  logic        p1_q, p2_q, pp_q;
  logic [11:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d, wdata_q, wdata_d, full;
  logic        we_q, we_d, err_q, err_d;
  logic        rx_valid, rx_ferr, byte_ok;
  logic [7:0]  rx_data;
  uart_rx_core u_rx (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_i           (uart_rx_i),
    .clks_per_bit_i (clks_per_bit_i),
    .valid_o        (rx_valid),
    .data_o         (rx_data),
    .frame_err_o    (rx_ferr)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    err_d   = err_q | (FRAME_CHECK & rx_valid & rx_ferr);
    byte_ok = rx_valid & !(FRAME_CHECK & rx_ferr);
    full    = word_q;
    full[{cnt_q, 3'b000} +: 8] = rx_data;
    if (state_q != LOAD) begin
      if (p2_q && !pp_q) begin
        state_d = LOAD;
        addr_d  = '0;
        cnt_d   = '0;
        word_d  = '0;
        err_d   = 1'b0;
      end
    end else if (!p2_q && pp_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      word_d  = '0;
    end else if (byte_ok) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = cnt_q == 2'd3 ? '0 : full;
      if (cnt_q == 2'd3) begin
        if (full == END_WORD) state_d = DONE;
        else begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = full;
          addr_d  = addr_q + 12'd1;
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      pp_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= prog_i;
      p2_q    <= p1_q;
      pp_q    <= p2_q;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  assign mem_we_o    = we_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = state_q == LOAD;
  assign done_o      = state_q == DONE;
  assign core_rst_o  = busy_o;
  assign err_o       = err_q;
endmodule

// File: tb/tb_iccm_uart_loader.sv
// tb_iccm_uart_loader: randomized UART word streams checked against a byte-level loader model.
module tb_iccm_uart_loader;
`ifdef LOADER_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, prog = 1'b0, uart = 1'b1;
  logic [15:0] cpb = 16'd16;
  logic        mem_we, core_rst, busy, done, err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  int          errors = 0, checks = 0;
  logic [43:0] got_q[$], exp_q[$];
  logic [7:0]  m_bytes[$];
  bit          m_load = 0, m_done = 0, m_err = 0;
  int          m_addr = 0;

  always #5 clk = ~clk;

  iccm_uart_loader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .prog_i         (prog),
    .uart_rx_i      (uart),
    .clks_per_bit_i (cpb),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .core_rst_o     (core_rst),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  always @(negedge clk) if (mem_we) got_q.push_back({mem_addr, mem_wdata});

  // Reference: what the loader should do with one received byte.
  task automatic m_byte(input logic [7:0] b, input logic stop);
    logic [31:0] w;
    if (!m_load || cpb < 16'd4) return;
    if (FC && !stop) begin m_err = 1; return; end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == 32'h0000_0FFF) begin m_load = 0; m_done = 1; end
      else begin
        exp_q.push_back({m_addr[11:0], w});
        m_addr = (m_addr + 1) % 4096;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart = f[i];
      repeat (cpb) @(negedge clk);
    end
    uart = 1'b1;
    repeat (4) @(negedge clk);
    m_byte(b, stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic prog_to(input logic v);
    logic was;
    was = prog;
    prog = v;
    repeat (6) @(negedge clk);
    if (v && !was && !m_load) begin
      m_load = 1; m_done = 0; m_addr = 0; m_err = 0; m_bytes.delete();
    end else if (!v && was && m_load) begin
      m_load = 0; m_bytes.delete();
    end
  endtask

  task automatic start_load;
    got_q.delete();
    exp_q.delete();
    prog_to(1'b0);
    prog_to(1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({mem_we, mem_addr, mem_wdata} !== 45'd0) begin errors++; $display("FAIL reset_mem: got %b/%h/%h, expected 0", mem_we, mem_addr, mem_wdata); end
    checks++; if ({core_rst, busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b%b, expected 00", core_rst, busy); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b%b, expected 00", done, err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b%b, expected 00", busy, done); end
  endtask

  task automatic test_single_word;
    cpb = 16'd16;
    start_load();
    checks++; if ({busy, core_rst} !== 2'b11) begin errors++; $display("FAIL load_busy: got %b%b, expected 11", busy, core_rst); end
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d, expected 1", got_q.size()); end
    else begin checks++; if (got_q[0] !== {12'd0, 32'h12345678}) begin errors++; $display("FAIL single_write: got %h, expected %h", got_q[0], {12'd0, 32'h12345678}); end end
    repeat (20) @(negedge clk);
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 12'd0, 32'h12345678}) begin errors++; $display("FAIL single_hold: got %b/%h/%h, expected 0/000/12345678", mem_we, mem_addr, mem_wdata); end
    checks++; if ({busy, core_rst, done} !== 3'b110) begin errors++; $display("FAIL single_state: got %b, expected 110", {busy, core_rst, done}); end
  endtask

  task automatic test_end_word;
    cpb = 16'($urandom_range(5, 12));
    start_load();
    send_word($urandom); send_word($urandom); send_word(32'h0000_0FFF);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL end_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL end_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
    checks++; if ({done, busy, core_rst} !== {m_done, m_load, m_load}) begin errors++; $display("FAIL end_state: got %b, expected %b", {done, busy, core_rst}, {m_done, m_load, m_load}); end
  endtask

  task automatic test_abort;
    logic [31:0] w;
    cpb = 16'($urandom_range(5, 12));
    start_load();
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);
    prog_to(1'b0);
    checks++; if ({busy, done, core_rst} !== 3'b000) begin errors++; $display("FAIL abort_state: got %b, expected 000", {busy, done, core_rst}); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL abort_nowrite: got %0d writes, expected 0", got_q.size()); end
    w = $urandom;
    prog_to(1'b1);
    send_word(w);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
  endtask

  task automatic test_glitch;
    cpb = 16'd16;
    start_load();
    uart = 1'b0;
    repeat (4) @(negedge clk);
    uart = 1'b1;
    repeat (40) @(negedge clk);
    send_word($urandom);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
  endtask

  task automatic test_slow_clk;
    cpb = 16'd8;
    start_load();
    cpb = 16'd3;
    send_byte(8'($urandom), 1'b1);
    cpb = 16'd8;
    repeat (10) @(negedge clk);
    send_word($urandom);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL slow_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL slow_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
  endtask

  task automatic test_frame;
    cpb = 16'd10;
    start_load();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    checks++; if (err !== m_err) begin errors++; $display("FAIL frame_err: got %b, expected %b", err, m_err); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
    prog_to(1'b0);
    checks++; if (err !== m_err) begin errors++; $display("FAIL frame_sticky: got %b, expected %b", err, m_err); end
    prog_to(1'b1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL frame_clear: got %b, expected 0", err); end
  endtask

  task automatic test_wrap;
    cpb = 16'd6;
    start_load();
    force dut.addr_q = 12'd4094;
    @(posedge clk);
    @(negedge clk);
    release dut.addr_q;
    m_addr = 4094;
    for (int i = 0; i < 3; i++) send_word($urandom);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
  endtask

  task automatic test_back_to_back;
    cpb = 16'd4;
    start_load();
    for (int i = 0; i < 6; i++) send_word($urandom);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end end
  endtask

  task automatic test_reset_mid;
    cpb = 16'd8;
    start_load();
    send_word($urandom | 32'h1); send_word($urandom | 32'h1);
    send_byte(8'($urandom), 1'b1);
    uart = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== 45'd0) begin errors++; $display("FAIL midrst_mem: got %b/%h/%h, expected 0", mem_we, mem_addr, mem_wdata); end
    checks++; if ({busy, core_rst, done, err} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b, expected 0000", {busy, core_rst, done, err}); end
    prog = 1'b0;
    uart = 1'b1;
    m_load = 0; m_done = 0; m_err = 0; m_addr = 0; m_bytes.delete();
    got_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_nowrite: got %0d writes, expected 0", got_q.size()); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_idle: got %b%b, expected 00", busy, done); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_end_word();
    test_abort();
    test_glitch();
    test_slow_clk();
    test_frame();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
